wishbone_arbiter: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares the CPU's single external bus port between the instruction-fetch bus interface (master 0) and the data load/store bus interface (master 1). Each master transfer is one single-beat classic cycle. Contention is resolved by alternating priority. A watchdog terminates a stalled transfer with an error so the pipeline never hangs. The block sits between the two CPU-side bus interfaces and the top-level bus.

---
 rtl/wishbone_arbiter.sv | 127 ++++++++++++
 tb/tb_wishbone_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter.sv
// Two-master, one-slave single-beat Wishbone arbiter with alternating priority
// and a watchdog that aborts a stalled grant with an error.
module wishbone_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [1:0]  grant_o,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t          state;
  logic            last1;
  logic [TO_W-1:0] to_cnt;

  logic req0, req1, to_hit, cur_cyc, cur_stb, abort;

  assign req0   = m0_cyc_i & m0_stb_i;
  assign req1   = m1_cyc_i & m1_stb_i;
  assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last1  <= 1'b0;
      to_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          // On contention the master that did not win last time gets the bus.
          if (req0 && req1) begin
            state <= last1 ? GRANT0 : GRANT1;
            last1 <= ~last1;
          end else if (req1) begin
            state <= GRANT1;
            last1 <= 1'b1;
          end else if (req0) begin
            state <= GRANT0;
            last1 <= 1'b0;
          end
        end
        GRANT0, GRANT1: begin
          if (s_ack_i || !cur_cyc || to_hit) state <= IDLE;
          else                               to_cnt <= to_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cur_cyc  = 1'b0;
    cur_stb  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_data_o = '0;
    grant_o  = 2'b00;
    case (state)
      GRANT0: begin
        cur_cyc  = m0_cyc_i;
        cur_stb  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        grant_o  = 2'b01;
      end
      GRANT1: begin
        cur_cyc  = m1_cyc_i;
        cur_stb  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

  // A late ack wins over the watchdog; an abandoned cycle gets neither.
  assign abort    = cur_cyc & ~s_ack_i & to_hit;
  assign s_cyc_o  = cur_cyc & ~abort;
  assign s_stb_o  = cur_stb & ~abort;

  assign m0_ack_o = (state == GRANT0) & s_ack_i;
  assign m1_ack_o = (state == GRANT1) & s_ack_i;
  assign m0_err_o = (state == GRANT0) & abort;
  assign m1_err_o = (state == GRANT1) & abort;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed scenarios then random traffic, every cycle
// checked against a transaction-level model of owner / wait count / priority.
module tb_wishbone_arbiter;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  grant_o;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wdat[2];
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i;

  int total = 0;
  int bad   = 0;

  // Model: who owns the bus (-1 none), grant cycles spent without ack, last winner.
  int owner   = -1;
  int waited  = 0;
  bit last_m1 = 1'b0;

  always #5 clk = ~clk;

  wishbone_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .grant_o(grant_o),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_wdat[0]), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_wdat[1]), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit timed_out();
    return owner >= 0 && !s_ack_i && m_cyc[owner] && waited == TIMEOUT - 1;
  endfunction

  // Let inputs settle, then compare every output to the model.
  task automatic eval();
    logic [1:0] eg;
    logic ecyc, estb, ewe, ea0, ea1, ee0, ee1;
    logic [3:0] esel;
    logic [31:0] eaddr, edat;
    bit to;
    #1;
    eg = 2'b00; ecyc = 0; estb = 0; ewe = 0; esel = 0; eaddr = 0; edat = 0;
    ea0 = 0; ea1 = 0; ee0 = 0; ee1 = 0;
    if (owner >= 0) begin
      to    = timed_out();
      eg    = (owner == 1) ? 2'b10 : 2'b01;
      ecyc  = m_cyc[owner] && !to;
      estb  = m_stb[owner] && !to;
      ewe   = m_we[owner];
      esel  = m_sel[owner];
      eaddr = m_addr[owner];
      edat  = m_wdat[owner];
      if (owner == 0) begin ea0 = s_ack_i; ee0 = to; end
      else            begin ea1 = s_ack_i; ee1 = to; end
    end
    chk("grant",  {30'd0, grant_o}, {30'd0, eg});
    chk("s_cyc",  {31'd0, s_cyc_o}, {31'd0, ecyc});
    chk("s_stb",  {31'd0, s_stb_o}, {31'd0, estb});
    chk("s_we",   {31'd0, s_we_o},  {31'd0, ewe});
    chk("s_sel",  {28'd0, s_sel_o}, {28'd0, esel});
    chk("s_addr", s_addr_o, eaddr);
    chk("s_data", s_data_o, edat);
    chk("m0_ack", {31'd0, m0_ack_o}, {31'd0, ea0});
    chk("m1_ack", {31'd0, m1_ack_o}, {31'd0, ea1});
    chk("m0_err", {31'd0, m0_err_o}, {31'd0, ee0});
    chk("m1_err", {31'd0, m1_err_o}, {31'd0, ee1});
    chk("m0_rdata", m0_data_o, s_data_i);
    chk("m1_rdata", m1_data_o, s_data_i);
  endtask

  // Advance the model over the coming rising edge, then move to the next falling edge.
  task automatic adv();
    bit r0, r1;
    r0 = m_cyc[0] && m_stb[0];
    r1 = m_cyc[1] && m_stb[1];
    if (rst) begin
      owner = -1; waited = 0; last_m1 = 0;
    end else if (owner < 0) begin
      if (r0 && r1) owner = last_m1 ? 0 : 1;
      else if (r1)  owner = 1;
      else if (r0)  owner = 0;
      if (owner >= 0) begin last_m1 = (owner == 1); waited = 0; end
    end else if (s_ack_i || !m_cyc[owner] || timed_out()) begin
      owner = -1;
    end else begin
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int m, input bit req, input bit we,
                       input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] d);
    m_cyc[m] = req; m_stb[m] = req; m_we[m] = we;
    m_sel[m] = sel; m_addr[m] = addr; m_wdat[m] = d;
  endtask

  initial begin
    rst = 1'b1; s_ack_i = 0; s_data_i = 32'h0;
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    eval(); adv();
    rst = 1'b0;
    eval(); adv();

    // m0 read with a zero-wait slave
    drive(0, 1, 0, 4'hF, 32'h0000_0100, 32'h0);
    eval(); adv();
    s_ack_i = 1; s_data_i = 32'h2402_0001;
    eval();
    chk("t1_grant", {30'd0, grant_o}, 32'd1);
    chk("t1_ack",   {31'd0, m0_ack_o}, 32'd1);
    chk("t1_data",  m0_data_o, 32'h2402_0001);
    adv();
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0); s_ack_i = 0;
    eval();
    chk("t1_idle", {30'd0, grant_o}, 32'd0);
    adv();

    // Both request continuously, zero-wait slave: m1, m0, m1 with idle gaps
    drive(0, 1, 0, 4'hF, 32'h0000_0200, 32'h0);
    drive(1, 1, 0, 4'hF, 32'h0000_0300, 32'h0);
    for (int k = 0; k < 3; k++) begin
      s_ack_i = 0; eval();
      chk("t2_gap", {30'd0, grant_o}, 32'd0);
      adv();
      s_ack_i = 1; s_data_i = 32'h1000 + k; eval();
      chk("t2_order", {30'd0, grant_o}, (k == 1) ? 32'd1 : 32'd2);
      adv();
    end
    s_ack_i = 0;
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    eval(); adv();

    // m1 write with 3 wait states while m0 waits
    drive(1, 1, 1, 4'b1100, 32'h8000_0010, 32'hDEAD_BEEF);
    eval(); adv();
    drive(0, 1, 0, 4'hF, 32'h0000_0400, 32'h0);
    for (int k = 0; k < 4; k++) begin
      s_ack_i = (k == 3);
      eval();
      chk("t3_addr", s_addr_o, 32'h8000_0010);
      chk("t3_m1ack", {31'd0, m1_ack_o}, (k == 3) ? 32'd1 : 32'd0);
      adv();
    end
    s_ack_i = 0;
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    eval(); adv();            // idle, m0 granted next
    s_ack_i = 1; eval(); adv();
    s_ack_i = 0; drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    eval(); adv();

    // Timeout on m0 with m1 pending
    drive(0, 1, 0, 4'hF, 32'h0000_0500, 32'h0);
    eval(); adv();
    drive(1, 1, 0, 4'hF, 32'h0000_0600, 32'h0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      eval();
      chk("t4_err", {31'd0, m0_err_o}, (k == TIMEOUT) ? 32'd1 : 32'd0);
      chk("t4_stb", {31'd0, s_stb_o},  (k == TIMEOUT) ? 32'd0 : 32'd1);
      adv();
    end
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    eval();
    chk("t4_idle", {30'd0, grant_o}, 32'd0);
    adv();
    eval();
    chk("t4_m1", {30'd0, grant_o}, 32'd2);
    // m1 abandons its cycle in grant cycle 2; m0 then gets the bus
    adv();
    drive(0, 1, 0, 4'hF, 32'h0000_0700, 32'h0);
    m_cyc[1] = 0;
    eval();
    chk("t5_noack", {31'd0, m1_ack_o | m1_err_o}, 32'd0);
    adv();
    eval();
    chk("t5_idle", {30'd0, grant_o}, 32'd0);
    adv();
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    eval();
    chk("t5_m0", {30'd0, grant_o}, 32'd1);

    // Async reset mid-grant
    rst = 1'b1;
    owner = -1; waited = 0; last_m1 = 0;
    eval();
    chk("t6_grant", {30'd0, grant_o}, 32'd0);
    chk("t6_cyc",   {31'd0, s_cyc_o}, 32'd0);
    adv();
    rst = 1'b0;
    drive(0, 1, 0, 4'hF, 32'h0000_0800, 32'h0);
    drive(1, 1, 0, 4'hF, 32'h0000_0900, 32'h0);
    eval(); adv();
    eval();
    chk("t6_first", {30'd0, grant_o}, 32'd2);
    adv();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        m_cyc[m]  = ($urandom_range(0, 9) < 7);
        m_stb[m]  = m_cyc[m] && ($urandom_range(0, 9) < 8);
        m_we[m]   = $urandom_range(0, 1);
        m_sel[m]  = 4'($urandom);
        m_addr[m] = $urandom;
        m_wdat[m] = $urandom;
      end
      s_ack_i  = ($urandom_range(0, 9) < 3);
      s_data_i = $urandom;
      eval(); adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
